reg_status: RTL and testbench
=============================

Name: reg_status

Overview:
- Architectural register file combined with a register-status (producer-tag) table for a Tomasulo-style out-of-order CPU.
- Each architectural register holds a data word and a functional-unit/reservation-station tag naming the pending producer; tag 0 means the value is valid.
- Three combinational read ports feed instruction issue (two source operands plus one extra, e.g. store data).
- One value write port serves commit/CDB; one tag write port serves issue.

Parameters:
- WORD_SIZE, 32, data word width.
- REG_INDEX, 5, register index width; NUM_REGS = 2**REG_INDEX (32).
- FU_INDEX, 4, tag width; tag 0 = "no pending producer".

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- get_num1/get_num2/get_num3  input  REG_INDEX  read-port register indices.
- v1/v2/v3  output  WORD_SIZE  value of the register selected by get_numN.
- q1/q2/q3  output  FU_INDEX  status tag of the register selected by get_numN.
- ws  input  REG_INDEX  value write index.
- wd  input  WORD_SIZE  value write data.
- we  input  1  value write enable.
- ws_rs  input  REG_INDEX  status write index.
- wd_rs  input  FU_INDEX  status write data (tag).
- we_rs  input  1  status write enable.
- Positional port order, used by existing instantiations: get_num1, get_num2, get_num3, v1, v2, v3, q1, q2, q3, ws, wd, we, ws_rs, wd_rs, we_rs, reset, clk.

Behaviour:
- Storage: val[NUM_REGS] of WORD_SIZE bits and tag[NUM_REGS] of FU_INDEX bits.
- Reads are purely combinational:
  - vN = val[get_numN], qN = tag[get_numN].
  - Zero latency; outputs follow index changes within the same cycle.
- Value write: on posedge clk with we=1, val[ws] <= wd.
- Status write: on posedge clk with we_rs=1, tag[ws_rs] <= wd_rs.
- The two write ports are independent:
  - Both may fire in the same cycle, including to the same register; each updates only its own array.
  - A value write does not clear the tag.
- No read bypass: a read of a register written in the current cycle returns the old contents until after the edge.
- Reset:
  - On posedge clk with reset=1, every val and every tag is cleared to 0.
  - Reset has priority over we/we_rs in that cycle.
  - After reset, all outputs read 0.
  - Reset may be asserted at any time, mid-sequence; no state survives it.
- Indices cover the full 0..NUM_REGS-1 range; no out-of-range case exists.
- Before the first reset, contents are undefined (X in simulation).

Optional Feature:
- Macro: REG_STATUS_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired: reads of index 0 return v=0 and q=0.
  - Writes to index 0 on either port are ignored.
- Undefined: register 0 behaves like every other register.

Decomposition:
- Shared package holds:
  - WORD_SIZE, REG_INDEX, FU_INDEX.
  - NUM_REGS.
  - FU_NONE = 0 (tag meaning "value ready").
- One natural sub-module: reg_array.
  - Parameterised width/depth, one write port, three combinational read ports, sync clear.
  - Instantiated twice: once for values (WORD_SIZE) and once for tags (FU_INDEX).

Test Plan:
- Reset high for one edge, then read indices 0,1,2 -> v1=v2=v3=0, q1=q2=q3=0.
- we=1, ws=2, wd=2, get_num3=2:
  - Before the edge -> v3=0.
  - After the edge -> v3=2, q3 unchanged (0).
- we_rs=1, ws_rs=3, wd_rs=3:
  - After the edge, get_num1=3 -> q1=3, v1=0.
  - Then we=1, ws=3, wd=7 -> v1=7, q1 still 3.
- Sweep 10 cycles incrementing get_num1..3, ws, wd, ws_rs, wd_rs by 1 each cycle (start ws=2, wd=2, ws_rs=3, wd_rs=3):
  - Each register k in 2..11 ends with val=k.
  - Each register k in 3..12 ends with tag=k.
  - All three read ports report these values once the sweep passes them.
- Same-cycle dual write: ws=ws_rs=5, wd=9, wd_rs=4 -> after the edge, index 5 reads v=9, q=4.
- we=0, we_rs=0 with ws=5, wd=1 -> register 5 unchanged. Then reset=1 together with we=1 (ws=5, wd=1) -> after the edge, register 5 reads v=0, q=0.

Source files
------------

// File: rtl/reg_status_pkg.sv
// Shared sizing constants for the register file / producer-tag table.
package reg_status_pkg;

  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned REG_INDEX = 5;
  localparam int unsigned FU_INDEX  = 4;
  localparam int unsigned NUM_REGS  = 1 << REG_INDEX;

  // Tag value meaning "no pending producer, value is ready"
  localparam logic [FU_INDEX-1:0] FU_NONE = '0;

endpackage

// File: rtl/reg_status_reg_array.sv
// Generic storage array: one write port, three combinational read ports, sync clear.
module reg_array #(
  parameter int unsigned W  = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic [AW-1:0] ra3,
  output logic [W-1:0]  rd1,
  output logic [W-1:0]  rd2,
  output logic [W-1:0]  rd3
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0] r_mem [DEPTH];

  // Clear has priority over the write port
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[wa] <= wd;
    end
  end

  // No bypass: reads see pre-edge contents
  assign rd1 = r_mem[ra1];
  assign rd2 = r_mem[ra2];
  assign rd3 = r_mem[ra3];

endmodule

// File: rtl/reg_status.sv
// Architectural register file plus producer-tag table for Tomasulo issue.
// Optional macro REG_STATUS_ZERO_REG_EN hardwires register 0 to value 0 / tag 0.
module reg_status
  import reg_status_pkg::*;
(
  input  logic [REG_INDEX-1:0] get_num1,
  input  logic [REG_INDEX-1:0] get_num2,
  input  logic [REG_INDEX-1:0] get_num3,
  output logic [WORD_SIZE-1:0] v1,
  output logic [WORD_SIZE-1:0] v2,
  output logic [WORD_SIZE-1:0] v3,
  output logic [FU_INDEX-1:0]  q1,
  output logic [FU_INDEX-1:0]  q2,
  output logic [FU_INDEX-1:0]  q3,
  input  logic [REG_INDEX-1:0] ws,
  input  logic [WORD_SIZE-1:0] wd,
  input  logic                 we,
  input  logic [REG_INDEX-1:0] ws_rs,
  input  logic [FU_INDEX-1:0]  wd_rs,
  input  logic                 we_rs,
  input  logic                 reset,
  input  logic                 clk
);

  logic                 w_we_val;
  logic                 w_we_tag;
  logic [WORD_SIZE-1:0] w_v1, w_v2, w_v3;
  logic [FU_INDEX-1:0]  w_q1, w_q2, w_q3;

  reg_array #(.W(WORD_SIZE), .AW(REG_INDEX)) u_val (
    .clk (clk),      .reset(reset),
    .we  (w_we_val), .wa   (ws),       .wd (wd),
    .ra1 (get_num1), .ra2  (get_num2), .ra3(get_num3),
    .rd1 (w_v1),     .rd2  (w_v2),     .rd3(w_v3)
  );

  reg_array #(.W(FU_INDEX), .AW(REG_INDEX)) u_tag (
    .clk (clk),      .reset(reset),
    .we  (w_we_tag), .wa   (ws_rs),    .wd (wd_rs),
    .ra1 (get_num1), .ra2  (get_num2), .ra3(get_num3),
    .rd1 (w_q1),     .rd2  (w_q2),     .rd3(w_q3)
  );

`ifdef REG_STATUS_ZERO_REG_EN
  // Register 0 ignores writes and always reads as ready zero
  assign w_we_val = we    & (ws    != '0);
  assign w_we_tag = we_rs & (ws_rs != '0);
  assign v1 = (get_num1 == '0) ? '0 : w_v1;
  assign v2 = (get_num2 == '0) ? '0 : w_v2;
  assign v3 = (get_num3 == '0) ? '0 : w_v3;
  assign q1 = (get_num1 == '0) ? FU_NONE : w_q1;
  assign q2 = (get_num2 == '0) ? FU_NONE : w_q2;
  assign q3 = (get_num3 == '0) ? FU_NONE : w_q3;
`else
  assign w_we_val = we;
  assign w_we_tag = we_rs;
  assign v1 = w_v1;
  assign v2 = w_v2;
  assign v3 = w_v3;
  assign q1 = w_q1;
  assign q2 = w_q2;
  assign q3 = w_q3;
`endif

endmodule

// File: tb/tb_reg_status.sv
// Self-checking bench for reg_status: directed scenarios plus random traffic vs. an array model.
module tb_reg_status;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  get_num1, get_num2, get_num3;
  logic [31:0] v1, v2, v3;
  logic [3:0]  q1, q2, q3;
  logic [4:0]  ws, ws_rs;
  logic [31:0] wd;
  logic [3:0]  wd_rs;
  logic        we, we_rs;

  int checks   = 0;
  int failures = 0;

`ifdef REG_STATUS_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic [31:0] mval [32];
  logic [3:0]  mtag [32];

  reg_status dut (
    .get_num1(get_num1), .get_num2(get_num2), .get_num3(get_num3),
    .v1(v1), .v2(v2), .v3(v3),
    .q1(q1), .q2(q2), .q3(q3),
    .ws(ws), .wd(wd), .we(we),
    .ws_rs(ws_rs), .wd_rs(wd_rs), .we_rs(we_rs),
    .reset(reset), .clk(clk)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_v(input logic [4:0] idx);
    if (ZERO_EN && idx == 5'd0) return 32'd0;
    return mval[idx];
  endfunction

  function automatic logic [31:0] exp_q(input logic [4:0] idx);
    if (ZERO_EN && idx == 5'd0) return 32'd0;
    return 32'(mtag[idx]);
  endfunction

  // Advance one clock; the model applies the same edge using the inputs currently driven
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mval[i] = 32'd0;
        mtag[i] = 4'd0;
      end
    end else begin
      if (we    && !(ZERO_EN && ws    == 5'd0)) mval[ws]    = wd;
      if (we_rs && !(ZERO_EN && ws_rs == 5'd0)) mtag[ws_rs] = wd_rs;
    end
    #1;
  endtask

  task automatic check_ports(input string tag);
    #1;
    chk({tag, "_v1"}, v1, exp_v(get_num1));
    chk({tag, "_v2"}, v2, exp_v(get_num2));
    chk({tag, "_v3"}, v3, exp_v(get_num3));
    chk({tag, "_q1"}, 32'(q1), exp_q(get_num1));
    chk({tag, "_q2"}, 32'(q2), exp_q(get_num2));
    chk({tag, "_q3"}, 32'(q3), exp_q(get_num3));
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; we_rs = 1'b0;
    ws = '0; wd = '0; ws_rs = '0; wd_rs = '0;
    get_num1 = 5'd0; get_num2 = 5'd1; get_num3 = 5'd2;
    #2;
    tick();
    reset = 1'b0;

    // Reset state
    #1;
    chk("rst_v1", v1, 32'd0); chk("rst_v2", v2, 32'd0); chk("rst_v3", v3, 32'd0);
    chk("rst_q1", 32'(q1), 32'd0); chk("rst_q2", 32'(q2), 32'd0); chk("rst_q3", 32'(q3), 32'd0);

    // Value write with no bypass before the edge
    we = 1'b1; ws = 5'd2; wd = 32'd2; get_num3 = 5'd2;
    #1;
    chk("wr2_pre_v3", v3, 32'd0);
    tick();
    we = 1'b0;
    #1;
    chk("wr2_post_v3", v3, 32'd2);
    chk("wr2_post_q3", 32'(q3), 32'd0);

    // Tag write, then value write keeps the tag
    we_rs = 1'b1; ws_rs = 5'd3; wd_rs = 4'd3;
    tick();
    we_rs = 1'b0; get_num1 = 5'd3;
    #1;
    chk("tag3_q1", 32'(q1), 32'd3);
    chk("tag3_v1", v1, 32'd0);
    we = 1'b1; ws = 5'd3; wd = 32'd7;
    tick();
    we = 1'b0;
    #1;
    chk("val3_v1", v1, 32'd7);
    chk("val3_q1", 32'(q1), 32'd3);

    // Incrementing sweep on both write ports
    we = 1'b1; we_rs = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ws = 5'(2 + i); wd = 32'(2 + i); ws_rs = 5'(3 + i); wd_rs = 4'(3 + i);
      get_num1 = 5'(2 + i); get_num2 = 5'(3 + i); get_num3 = 5'(4 + i);
      check_ports("sweep");
      tick();
    end
    we = 1'b0; we_rs = 1'b0;
    for (int k = 2; k <= 12; k++) begin
      get_num1 = 5'(k); get_num2 = 5'(k); get_num3 = 5'(k);
      #1;
      if (k <= 11) begin
        chk("sweep_val_v1", v1, 32'(k));
        chk("sweep_val_v3", v3, 32'(k));
      end
      if (k >= 3) begin
        chk("sweep_tag_q2", 32'(q2), 32'(k));
        chk("sweep_tag_q3", 32'(q3), 32'(k));
      end
    end

    // Same-cycle dual write to one register
    we = 1'b1; we_rs = 1'b1; ws = 5'd5; ws_rs = 5'd5; wd = 32'd9; wd_rs = 4'd4;
    tick();
    we = 1'b0; we_rs = 1'b0; get_num2 = 5'd5;
    #1;
    chk("dual_v2", v2, 32'd9);
    chk("dual_q2", 32'(q2), 32'd4);

    // Disabled write leaves state; reset beats a concurrent write
    ws = 5'd5; wd = 32'd1;
    tick();
    #1;
    chk("nowe_v2", v2, 32'd9);
    chk("nowe_q2", 32'(q2), 32'd4);
    reset = 1'b1; we = 1'b1;
    tick();
    reset = 1'b0; we = 1'b0;
    #1;
    chk("rstwr_v2", v2, 32'd0);
    chk("rstwr_q2", 32'(q2), 32'd0);

    // Register 0 handling under both builds
    we = 1'b1; we_rs = 1'b1; ws = 5'd0; ws_rs = 5'd0; wd = 32'hDEAD_BEEF; wd_rs = 4'hA;
    get_num1 = 5'd0;
    tick();
    we = 1'b0; we_rs = 1'b0;
    check_ports("reg0");

    // Random traffic against the model, occasional mid-sequence reset
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 39) == 0);
      we       = 1'($urandom);
      we_rs    = 1'($urandom);
      ws       = 5'($urandom);
      wd       = $urandom;
      ws_rs    = 5'($urandom);
      wd_rs    = 4'($urandom);
      get_num1 = ($urandom_range(0, 3) == 0) ? ws : 5'($urandom);
      get_num2 = ($urandom_range(0, 3) == 0) ? ws_rs : 5'($urandom);
      get_num3 = 5'($urandom);
      check_ports("rand");
      tick();
    end
    reset = 1'b0; we = 1'b0; we_rs = 1'b0;
    for (int k = 0; k < 32; k++) begin
      get_num1 = 5'(k); get_num2 = 5'(31 - k); get_num3 = 5'(k);
      check_ports("final");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
